// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns a stream of UART bytes into validated command frames
// (SOF, CMD, LEN, payload, CHK). A validated command is held on cmd_* until acked.
//
// Ports:
//   clk_i, rst_ni        clock and synchronous active-low reset
//   rx_byte_i/rx_done_i  byte and done strobe from the UART receiver (other clock domain)
//   rx_error_i           receiver error level (other clock domain)
//   cmd_valid_o/cmd_ack_i  command handshake; cmd_id_o / cmd_len_o describe held command
//   pl_raddr_i/pl_rdata_o  payload buffer read port, 1-cycle registered latency
//   err_*_o              1-cycle error pulses (chk, len, timeout, rx)
//   drop_cnt_o           saturating count of bytes dropped while a command is held
module uart_cmd_parser #(
  parameter logic [7:0]   Sof        = 8'h7E,
  parameter int unsigned  MaxLen     = 16,
  parameter int unsigned  TimeoutCyc = 50000,
  localparam int unsigned LenW       = $clog2(MaxLen + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      rx_byte_i,
  input  logic            rx_done_i,
  input  logic            rx_error_i,
  output logic            cmd_valid_o,
  input  logic            cmd_ack_i,
  output logic [7:0]      cmd_id_o,
  output logic [LenW-1:0] cmd_len_o,
  input  logic [LenW-1:0] pl_raddr_i,
  output logic [7:0]      pl_rdata_o,
  output logic            err_chk_o,
  output logic            err_len_o,
  output logic            err_timeout_o,
  output logic            err_rx_o,
  output logic [7:0]      drop_cnt_o
);

  localparam int unsigned CntW  = $clog2(TimeoutCyc + 1);
  localparam int unsigned RamAw = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StChk, StHold} state_e;

  state_e          state_q, state_d;
  logic [2:0]      done_sync_q, err_sync_q;  // [1:0] synchroniser, [2] edge history
  logic            stb_q, rxerr_q;
  logic [7:0]      byte_q;
  logic [7:0]      chk_q, chk_d, id_q, id_d, cmd_id_q, cmd_id_d, drop_q, drop_d;
  logic [LenW-1:0] len_q, len_d, idx_q, idx_d, cmd_len_q, cmd_len_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_chk_q, err_chk_d, err_len_q, err_len_d;
  logic            err_to_q, err_to_d, err_rx_q, err_rx_d;
  logic            active, timeout, proceed, wr_en;
  logic [7:0]      mem_q [2**RamAw];
  logic [7:0]      rdata_q;

  // CDC: 2-flop synchronisers, then registered rising-edge detect.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_sync_q <= '0;
      err_sync_q  <= '0;
      stb_q       <= 1'b0;
      rxerr_q     <= 1'b0;
      byte_q      <= '0;
    end else begin
      done_sync_q <= {done_sync_q[1:0], rx_done_i};
      err_sync_q  <= {err_sync_q[1:0], rx_error_i};
      stb_q       <= done_sync_q[1] & ~done_sync_q[2];
      rxerr_q     <= err_sync_q[1] & ~err_sync_q[2];
      if (done_sync_q[1] & ~done_sync_q[2]) byte_q <= rx_byte_i;
    end
  end

  assign active  = (state_q == StCmd) || (state_q == StLen) ||
                   (state_q == StPayload) || (state_q == StChk);
  assign timeout = active && (cnt_q == CntW'(TimeoutCyc - 1));
  // A byte is parsed only if no abort (rx error or timeout) takes this cycle.
  assign proceed = stb_q && !(active && rxerr_q) && !timeout;

  always_comb begin
    state_d   = state_q;
    chk_d     = chk_q;
    id_d      = id_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cmd_id_d  = cmd_id_q;
    cmd_len_d = cmd_len_q;
    drop_d    = drop_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    err_rx_d  = 1'b0;
    wr_en     = 1'b0;

    if (rxerr_q) begin
      err_rx_d = 1'b1;
      if (active) state_d = StIdle;
    end else if (timeout) begin
      err_to_d = 1'b1;
      state_d  = StIdle;
    end

    case (state_q)
      StIdle: begin
        if (proceed && byte_q == Sof) state_d = StCmd;
      end
      StCmd: begin
        if (proceed) begin
          id_d    = byte_q;
          chk_d   = byte_q;
          state_d = StLen;
        end
      end
      StLen: begin
        if (proceed) begin
          chk_d = chk_q ^ byte_q;
          if (byte_q > 8'(MaxLen)) begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end else begin
            len_d   = byte_q[LenW-1:0];
            idx_d   = '0;
            state_d = (byte_q == 8'h00) ? StChk : StPayload;
          end
        end
      end
      StPayload: begin
        if (proceed) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ byte_q;
          idx_d = idx_q + LenW'(1);
          if (idx_q == len_q - LenW'(1)) state_d = StChk;
        end
      end
      StChk: begin
        if (proceed) begin
          if (byte_q == chk_q) begin
            state_d   = StHold;
            cmd_id_d  = id_q;
            cmd_len_d = len_q;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StHold: begin
        // rx errors do not disturb a held command; bytes are counted, not parsed.
        if (stb_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (cmd_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Timeout counter clears on every byte and on every state entry.
    if (!active || stb_q || state_d != state_q) cnt_d = '0;
    else                                        cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      chk_q     <= '0;
      id_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      cmd_id_q  <= '0;
      cmd_len_q <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_rx_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      chk_q     <= chk_d;
      id_q      <= id_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cmd_id_q  <= cmd_id_d;
      cmd_len_q <= cmd_len_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      err_rx_q  <= err_rx_d;
      if (pl_raddr_i < LenW'(MaxLen)) rdata_q <= mem_q[pl_raddr_i[RamAw-1:0]];
      else                            rdata_q <= '0;
    end
  end

  // Payload buffer: contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[idx_q[RamAw-1:0]] <= byte_q;
  end

  assign cmd_valid_o   = (state_q == StHold);
  assign cmd_id_o      = cmd_id_q;
  assign cmd_len_o     = cmd_len_q;
  assign pl_rdata_o    = rdata_q;
  assign err_chk_o     = err_chk_q;
  assign err_len_o     = err_len_q;
  assign err_timeout_o = err_to_q;
  assign err_rx_o      = err_rx_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver. It consumes received bytes and assembles them into command frames. Each frame is SOF, CMD, LEN, LEN payload bytes, CHK.
It validates length and checksum, buffers the payload, and presents one command at a time to the monitor control logic through a valid/ack handshake. It also flags framing errors, inter-byte timeouts and receiver errors.

Parameters:
SOF, 8'h7E, start-of-frame byte
MAX_LEN, 16, maximum payload bytes (1..255)
TIMEOUT_CYC, 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz)
LEN_W, $clog2(MAX_LEN+1), derived; width of cmd_len

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-low; low on a rising clk edge resets the block
rx_byte  in  8  byte from UART receiver; stable while rx_done high
rx_done  in  1  receiver done, baud_rx domain; high for at least 1 baud_rx period per byte
rx_error  in  1  receiver error, baud_rx domain
cmd_valid  out  1  complete validated command available
cmd_ack  in  1  consumer accepts command
cmd_id  out  8  CMD byte of held command
cmd_len  out  LEN_W  payload length of held command
pl_raddr  in  LEN_W  payload read address
pl_rdata  out  8  payload byte at pl_raddr, 1-cycle registered latency
err_chk  out  1  1-cycle pulse: checksum mismatch
err_len  out  1  1-cycle pulse: LEN > MAX_LEN
err_timeout  out  1  1-cycle pulse: inter-byte timeout
err_rx  out  1  1-cycle pulse: rx_error rising edge
drop_cnt  out  8  saturating count of bytes dropped while a command is held

Behaviour:
- Reset (reset low on a rising clk edge):
  - state=IDLE; cmd_valid, all err_* =0; cmd_id=0, cmd_len=0, drop_cnt=0, pl_rdata=0.
  - Sync flops and timeout counter are cleared. Payload RAM contents are don't-care.
  - Reset wins over every other event, including mid-frame.
- CDC and byte capture:
  - rx_done and rx_error each pass through a 2-flop synchroniser into clk, then a rising-edge detect.
  - byte_stb asserts for 1 cycle, 3 clk cycles (±1) after rx_done rises. rx_byte is captured into a register on byte_stb.
  - A single rx_done high period yields exactly one byte_stb.
- Checksum: running XOR of CMD, LEN and all payload bytes. SOF and CHK are excluded.
- FSM, all transitions on byte_stb unless noted:
  - IDLE: byte==SOF -> CMD. Any other byte is ignored and not counted.
  - CMD: latch id, chk=byte -> LEN.
  - LEN:
    - byte>MAX_LEN -> err_len pulse, IDLE.
    - byte==0 -> CHK.
    - otherwise latch len, idx=0 -> PAYLOAD.
    - chk^=byte in all cases.
  - PAYLOAD: RAM[idx]=byte, chk^=byte, idx++. When idx==len-1 is written -> CHK.
  - CHK:
    - byte==chk -> HOLD; cmd_valid=1 on the next cycle; cmd_id and cmd_len update on the same cycle.
    - byte!=chk -> err_chk pulse, IDLE.
  - HOLD:
    - cmd_valid stays high; cmd_id, cmd_len and RAM are frozen.
    - Each byte_stb increments drop_cnt, saturating at 255. Dropped bytes are not parsed.
    - cmd_ack high while cmd_valid=1 -> cmd_valid=0 next cycle, state IDLE.
    - A byte_stb in the same cycle as the ack is dropped and counted.
- Timeout:
  - A counter runs in CMD, LEN, PAYLOAD and CHK. It clears on each byte_stb and on every state entry.
  - Reaching TIMEOUT_CYC-1 -> err_timeout pulse, IDLE.
  - No timeout in IDLE or HOLD.
- rx_error edge:
  - In any state it produces an err_rx pulse.
  - In CMD, LEN, PAYLOAD or CHK it also aborts to IDLE, discarding that cycle's byte_stb.
  - In IDLE or HOLD the state is unaffected.
- Error priority when simultaneous: err_rx > err_timeout > err_len/err_chk. Only one err_* pulses per cycle.
- Payload read:
  - pl_rdata <= RAM[pl_raddr] every clk.
  - Reads at addresses ≥ cmd_len return don't-care.
- drop_cnt clears only on reset.

Test Plan:
- Good frame 7E 01 02 AA 55 FC -> cmd_valid=1, cmd_id=01, cmd_len=2; pl_raddr=0 gives AA and 1 gives 55, each one cycle later; no err_* pulses.
- Same frame with CHK=FD -> single err_chk pulse, cmd_valid stays 0. A following good frame is accepted.
- 7E 03 11 (LEN 17 > MAX_LEN 16) -> err_len pulse after the LEN byte; subsequent 7E 05 00 05 -> cmd_valid with cmd_id=05, cmd_len=0.
- Junk 00 FF 12 then 7E 01, then idle TIMEOUT_CYC cycles -> err_timeout pulse exactly once, state IDLE, drop_cnt=0; the next good frame is accepted.
- Good frame held with no ack, then 3 more bytes -> drop_cnt=3, cmd_id and payload unchanged. cmd_ack=1 for 1 cycle -> cmd_valid=0 next cycle.
- Reset low for 1 cycle mid-PAYLOAD -> all outputs at reset values. rx_error pulse mid-frame -> err_rx and abort. A good frame afterward is parsed correctly.
